// File: rtl/display_pkg.sv
// Shared seven-segment display types and active-low segment patterns {g,f,e,d,c,b,a}.
package display_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_OFF   = 7'b1111111;

  localparam seg7_t SEG_HEX_0 = 7'b1000000;
  localparam seg7_t SEG_HEX_1 = 7'b1111001;
  localparam seg7_t SEG_HEX_2 = 7'b0100100;
  localparam seg7_t SEG_HEX_3 = 7'b0110000;
  localparam seg7_t SEG_HEX_4 = 7'b0011001;
  localparam seg7_t SEG_HEX_5 = 7'b0010010;
  localparam seg7_t SEG_HEX_6 = 7'b0000010;
  localparam seg7_t SEG_HEX_7 = 7'b1111000;
  localparam seg7_t SEG_HEX_8 = 7'b0000000;
  localparam seg7_t SEG_HEX_9 = 7'b0010000;
  localparam seg7_t SEG_HEX_A = 7'b0001000;
  localparam seg7_t SEG_HEX_B = 7'b0000011;
  localparam seg7_t SEG_HEX_C = 7'b1000110;
  localparam seg7_t SEG_HEX_D = 7'b0100001;
  localparam seg7_t SEG_HEX_E = 7'b0000110;
  localparam seg7_t SEG_HEX_F = 7'b0001110;

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble to active-low seven-segment pattern decoder.
module hex7seg
  import display_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg7_t      seg_c
);

  always_comb begin
    seg_c = SEG_OFF;
    case (nib_i)
      4'h0: seg_c = SEG_HEX_0;
      4'h1: seg_c = SEG_HEX_1;
      4'h2: seg_c = SEG_HEX_2;
      4'h3: seg_c = SEG_HEX_3;
      4'h4: seg_c = SEG_HEX_4;
      4'h5: seg_c = SEG_HEX_5;
      4'h6: seg_c = SEG_HEX_6;
      4'h7: seg_c = SEG_HEX_7;
      4'h8: seg_c = SEG_HEX_8;
      4'h9: seg_c = SEG_HEX_9;
      4'hA: seg_c = SEG_HEX_A;
      4'hB: seg_c = SEG_HEX_B;
      4'hC: seg_c = SEG_HEX_C;
      4'hD: seg_c = SEG_HEX_D;
      4'hE: seg_c = SEG_HEX_E;
      4'hF: seg_c = SEG_HEX_F;
      default: seg_c = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/an_scan_ctrl.sv
// Time-multiplexed common-anode seven-segment scan controller with per-slot blank gap.
// Optional leading-zero blanking is enabled by defining BLANK_LZ_EN.
module an_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
)
(
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [4*NUM_DIGITS-1:0]       HEX_IN,
  input  logic [NUM_DIGITS-1:0]         DIGIT_EN,
  output logic [NUM_DIGITS-1:0]         AN,
  output seg7_t                         SEG,
  output logic [$clog2(NUM_DIGITS)-1:0] DIGIT_SEL,
  output logic                          SCAN_TICK
);

  localparam int unsigned IDXW = $clog2(NUM_DIGITS);
  localparam int unsigned PCW  = $clog2(REFRESH_DIV);
  localparam int unsigned HEXW = 4 * NUM_DIGITS;

  logic [PCW-1:0]        pc_q, pc_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [HEXW-1:0]       hex_q, hex_d;
  logic                  fresh_q;
  logic [3:0]            nib_d;
  logic                  en_d;
  logic                  lz_d;
  logic                  lit_d;
  logic [NUM_DIGITS-1:0] an_d;
  seg7_t                 seg_hex;
  seg7_t                 seg_d;
  logic                  tick_d;

  // Next-state counters, slot capture and digit select; outputs follow next-state values.
  always_comb begin
    pc_d  = pc_q + PCW'(1);
    idx_d = idx_q;
    if (pc_q == PCW'(REFRESH_DIV - 1)) begin
      pc_d  = '0;
      idx_d = (idx_q == IDXW'(NUM_DIGITS - 1)) ? '0 : idx_q + IDXW'(1);
    end

    // Word is captured entering each slot, and once right after reset release.
    hex_d = hex_q;
    if ((pc_d == '0) || fresh_q) begin
      hex_d = HEX_IN;
    end

    nib_d = 4'h0;
    en_d  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDXW'(i)) begin
        nib_d = hex_d[4*i +: 4];
        en_d  = DIGIT_EN[i];
      end
    end

    lit_d = en_d && !lz_d && (32'(pc_d) >= 32'(BLANK_CYCLES));

    an_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (lit_d && (idx_d == IDXW'(i))) begin
        an_d[i] = 1'b0;
      end
    end

    seg_d  = lit_d ? seg_hex : SEG_OFF;
    tick_d = (pc_d == PCW'(REFRESH_DIV - 1));
  end

`ifdef BLANK_LZ_EN
  logic upper_zero;

  // Walk from the top digit down; a digit is dark while it and everything above is zero.
  always_comb begin
    lz_d       = 1'b0;
    upper_zero = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (hex_d[4*i +: 4] == 4'h0);
      if ((idx_d == IDXW'(i)) && (i != 0)) begin
        lz_d = upper_zero;
      end
    end
  end
`else
  assign lz_d = 1'b0;
`endif

  hex7seg u_hex7seg (
    .nib_i (nib_d),
    .seg_c (seg_hex)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q      <= '0;
      idx_q     <= '0;
      hex_q     <= '0;
      fresh_q   <= 1'b1;
      AN        <= '1;
      SEG       <= SEG_OFF;
      DIGIT_SEL <= '0;
      SCAN_TICK <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      idx_q     <= idx_d;
      hex_q     <= hex_d;
      fresh_q   <= 1'b0;
      AN        <= an_d;
      SEG       <= seg_d;
      DIGIT_SEL <= idx_d;
      SCAN_TICK <= tick_d;
    end
  end

endmodule

// File: tb/tb_an_scan_ctrl.sv
// Scoreboard bench for an_scan_ctrl: directed stimulus pushes per-cycle expectations, a monitor checks them.
module tb_an_scan_ctrl;

  localparam int unsigned ND = 4;
  localparam int unsigned RD = 8;
  localparam int unsigned BC = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] HEX_IN = 16'h1234;
  logic [3:0]  DIGIT_EN = 4'hF;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic [1:0]  DIGIT_SEL;
  logic        SCAN_TICK;

  typedef struct packed {
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [1:0]  sel;
    logic        tick;
    logic [7:0]  ph;
    logic [15:0] cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned t = 0;
  int unsigned cyc_n = 0;
  logic [15:0] cap = 16'h0;
  logic [3:0]  en_prev = 4'hF;
  logic [7:0]  phase = 8'd0;
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 CLK = ~CLK;

  an_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) u_dut (
    .CLK       (CLK),
    .RST       (RST),
    .HEX_IN    (HEX_IN),
    .DIGIT_EN  (DIGIT_EN),
    .AN        (AN),
    .SEG       (SEG),
    .DIGIT_SEL (DIGIT_SEL),
    .SCAN_TICK (SCAN_TICK)
  );

  // One clock: predict this cycle's outputs from the schedule, then drive inputs for the next edge.
  task automatic cycle(input logic rst_v, input logic [15:0] h, input logic [3:0] e);
    exp_t        x;
    int unsigned pc;
    int unsigned slot;
    logic        lit;
    logic [3:0]  nib;
    @(posedge CLK);
    #1;
    pc   = t % RD;
    slot = (t / RD) % ND;
    nib  = cap[4*slot +: 4];
    lit  = (pc >= BC) && en_prev[slot];
`ifdef BLANK_LZ_EN
    if ((slot > 0) && ((cap >> (4*slot)) == 16'h0)) lit = 1'b0;
`endif
    x.an   = lit ? ~(4'b0001 << slot) : 4'hF;
    x.seg  = lit ? seg_tab[nib] : 7'h7F;
    x.sel  = 2'(slot);
    x.tick = (pc == RD - 1);
    x.ph   = phase;
    x.cyc  = 16'(cyc_n);
    exp_q.push_back(x);
    RST      = rst_v;
    HEX_IN   = h;
    DIGIT_EN = e;
    en_prev  = e;
    cyc_n++;
    if (rst_v) begin
      t = 0;
    end else begin
      if ((t == 0) || (pc == RD - 1)) cap = h;
      t++;
    end
  endtask

  task automatic run(input int n, input logic [15:0] h, input logic [3:0] e);
    for (int i = 0; i < n; i++) cycle(1'b0, h, e);
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      checks++;
      if ({AN, SEG, DIGIT_SEL, SCAN_TICK} !== {x.an, x.seg, x.sel, x.tick}) begin
        errors++;
        $display("FAIL phase%0d cyc%0d: got AN=%b SEG=%h SEL=%0d TICK=%b, want AN=%b SEG=%h SEL=%0d TICK=%b",
                 x.ph, x.cyc, AN, SEG, DIGIT_SEL, SCAN_TICK, x.an, x.seg, x.sel, x.tick);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge CLK);
    #1;
    // Reset held for three edges in total, then the first released cycle.
    phase = 8'd1;
    cycle(1'b1, 16'h1234, 4'hF);
    cycle(1'b1, 16'h1234, 4'hF);
    // Full scan of 1234 with every digit enabled.
    phase = 8'd2;
    run(40, 16'h1234, 4'hF);
    // Digit 2 disabled; its slot is still consumed.
    phase = 8'd3;
    run(32, 16'h1234, 4'b1011);
    // Zero word, then change to 000F in the middle of slot 0.
    phase = 8'd4;
    run(28, 16'h0000, 4'hF);
    run(36, 16'h000F, 4'hF);
    // Leading-zero candidate word.
    phase = 8'd5;
    run(40, 16'h0050, 4'hF);
    // Reach slot 2, pc 5 and reset in that cycle.
    phase = 8'd6;
    run(5, 16'h0050, 4'hF);
    cycle(1'b1, 16'h1234, 4'hF);
    phase = 8'd7;
    run(20, 16'h1234, 4'hF);
    repeat (3) @(negedge CLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/an_scan_ctrl.md
# an_scan_ctrl

Parametrised time-multiplexed scan controller for the board's common-anode seven-segment display. It owns the refresh prescaler and the digit-scan counter, drives one active-low anode at a time, and drives the matching active-low segment pattern decoded from a packed hex word. Per-digit enables and a ghosting blank gap at the start of each slot are included. It sits between the datapath's display register and the top-level AN/SEG pins, and replaces the hand-fed two-bit anode decode.

## Interface
- NUM_DIGITS, 8: number of digits scanned; legal range 2..16.
- REFRESH_DIV, 100000: clock cycles per digit slot; must be ≥ BLANK_CYCLES+2.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off; 0 disables the gap.
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- HEX_IN  in  4*NUM_DIGITS  packed hex digits; digit i is HEX_IN[4i+3:4i].
- DIGIT_EN  in  NUM_DIGITS  per-digit enable; 0 keeps that anode off while its slot is still consumed.
- AN  out  NUM_DIGITS  anode drive, active low, at most one bit low.
- SEG  out  7  segments {g,f,e,d,c,b,a}, active low.
- DIGIT_SEL  out  $clog2(NUM_DIGITS)  index of the current slot.
- SCAN_TICK  out  1  one-cycle pulse in the last cycle of each slot.

## Operation
- State:
  - prescaler `pc` counts 0..REFRESH_DIV-1, then wraps to 0.
  - slot index `idx` counts 0..NUM_DIGITS-1; it advances on the edge where `pc` wraps.
  - wrap: NUM_DIGITS-1 → 0. Non-power-of-two NUM_DIGITS must never reach an out-of-range index.
- Digit capture:
  - the current nibble `nib` is latched from HEX_IN on the first cycle of each slot (`pc`==0) and held for the whole slot.
  - HEX_IN changes mid-slot have no effect until the next slot.
- Anode rule: AN[i]=0 iff i==idx && DIGIT_EN[i]==1 && `pc`≥BLANK_CYCLES && the digit is not lz-blanked. All other bits are 1.
- Segment rule:
  - SEG = hex7seg(`nib`) for 0..F, standard Basys-style patterns (e.g. 0→7'b1000000, 8→7'b0000000, F→7'b0001110).
  - SEG = 7'b1111111 whenever all AN bits are 1.
- DIGIT_EN is sampled every cycle, so clearing it turns the anode off on the next edge.
- SCAN_TICK=1 iff `pc`==REFRESH_DIV-1.
- Reset: `pc`=0, `idx`=0, `nib`=0, AN all 1, SEG all 1, DIGIT_SEL=0, SCAN_TICK=0. Reset asserted mid-slot aborts the slot immediately and returns to these values.

## Timing
- All outputs are registered. Each output equals the rule above evaluated on the `pc`/`idx` values held in the same cycle; implement by computing from next-state.
- No combinational path from any input to any output.
- First cycle after RST falls: `pc`=0, `idx`=0, AN all 1.
  - With BLANK_CYCLES=0, the edge at the end of that cycle drives AN[0] low, using the nibble captured on that same edge.
  - Otherwise AN[0] goes low when `pc` first equals BLANK_CYCLES.
- Full scan period = NUM_DIGITS × REFRESH_DIV cycles. Per-digit on-time = REFRESH_DIV − BLANK_CYCLES cycles.

## Configuration
- BLANK_LZ_EN defined:
  - digit i>0 is lz-blanked when its nibble and every higher-index nibble of the slot-captured value are 0.
  - digit 0 is never lz-blanked.
  - higher nibbles are compared from HEX_IN as captured at the start of the current slot.
- BLANK_LZ_EN undefined: no digit is ever lz-blanked; zeros display as 0.

## Structure
- Shared package `display_pkg`:
  - seg7_t (logic [6:0]).
  - SEG_OFF constant (7'b1111111).
  - hex digit segment constants.
- One sub-module `hex7seg` (purely combinational nibble→seg7_t), also reusable elsewhere.
- Counters, capture, lz-blanking and output registers live in an_scan_ctrl.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset: hold RST 3 cycles, release → AN=4'b1111, SEG=7'h7F, DIGIT_SEL=0, SCAN_TICK=0; AN=4'b1110 first appears when `pc`==2.
- Scan order: HEX_IN=16'h1234, all enabled →
  - AN sequence 1110, 1101, 1011, 0111, each low for 6 of 8 cycles.
  - SEG shows 4, 3, 2, 1 in turn.
  - SCAN_TICK every 8 cycles; period 32 cycles.
- Disable: DIGIT_EN=4'b1011 → slot 2 keeps AN=1111 and SEG=7'h7F for all 8 cycles; the scan period stays at 32.
- Capture: change HEX_IN 16'h0000→16'h000F mid-slot 0 → digit 0 still shows 0 for the rest of the slot, and F on its next slot.
- Leading-zero blanking: with BLANK_LZ_EN and HEX_IN=16'h0050 → digits 3 and 2 are dark, digit 1 shows 5, digit 0 shows 0. Without BLANK_LZ_EN, all four digits light.
- Mid-slot reset: assert RST with `idx`=2, `pc`=5 → next cycle AN=1111 and DIGIT_SEL=0; the scan restarts at digit 0.
